// File: rtl/tc_multi_scan.sv
// Multi-channel MAX31855 thermocouple scanner behind an AXI4-Lite register file.
// One shared SCLK/MISO bus, one active-low chip select per channel, sticky per-channel alarms.
module tc_multi_scan #(
    parameter int CHANNELS           = 4,
    parameter int CLK_DIV            = 10,
    parameter int TIMER_INIT         = 100000,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            SCLK,
    output logic [CHANNELS-1:0]             CSn,
    input  logic                            MISO,
    output logic                            irq
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_M1  = 16'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_COMMIT, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [15:0]         cnt_q, cnt_d, scan_cnt_q, scan_cnt_d;
    logic [4:0]          bit_q, bit_d;
    logic [31:0]         sh_q, sh_d, timer_q, timer_d, timer_lmt_q, timer_lmt_d;
    logic                sclk_q, sclk_d, irq_q, irq_d;
    logic                timer_en_q, timer_en_d, irq_en_q, irq_en_d;
    logic [CHANNELS-1:0] csn_q, csn_d, mask_q, mask_d, alarm_q, alarm_d;
    logic [31:0]         data_q [CHANNELS];
    logic [31:0]         data_d [CHANNELS];
    logic [13:0]         hlim_q [CHANNELS];
    logic [13:0]         hlim_d [CHANNELS];
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                wr_en, rd_en, start, tick, busy;
    logic                first_ok, next_ok;
    logic [CH_W-1:0]     first_ch, next_ch;
    logic [CHANNELS-1:0] w1c, alarm_set;
    logic [5:0]          wa, ra;

    assign busy  = (state_q != S_IDLE);
    assign wr_en = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
    assign rd_en = s_axi_arvalid & ~rvalid_q;
    assign wa    = s_axi_awaddr[7:2];
    assign ra    = s_axi_araddr[7:2];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        sclk_d      = sclk_q;
        csn_d       = csn_q;
        scan_cnt_d  = scan_cnt_q;
        timer_en_d  = timer_en_q;
        irq_en_d    = irq_en_q;
        timer_lmt_d = timer_lmt_q;
        mask_d      = mask_q;
        data_d      = data_q;
        hlim_d      = hlim_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        start       = 1'b0;
        w1c         = '0;
        alarm_set   = '0;
        tick        = 1'b0;

        // Lowest enabled channel overall, and lowest enabled channel above the current one
        first_ok = 1'b0;
        first_ch = '0;
        next_ok  = 1'b0;
        next_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ok = 1'b1;
                first_ch = CH_W'(i);
            end
            if (mask_q[i] && i > int'(ch_q)) begin
                next_ok = 1'b1;
                next_ch = CH_W'(i);
            end
        end

        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = 2'b00;
            case (wa)
                6'h00: begin
                    start      = s_axi_wdata[0];
                    timer_en_d = s_axi_wdata[1];
                    irq_en_d   = s_axi_wdata[2];
                end
                6'h02: timer_lmt_d = s_axi_wdata;
                6'h03: mask_d = s_axi_wdata[CHANNELS-1:0];
                6'h04: w1c = s_axi_wdata[CHANNELS-1:0];
                default: begin
                    if (wa[5:4] == 2'b10 && int'(wa[3:0]) < CHANNELS)
                        hlim_d[wa[CH_W-1:0]] = s_axi_wdata[13:0];
                    else
                        bresp_d = 2'b10;
                end
            endcase
        end

        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = 2'b00;
            case (ra)
                6'h00: rdata_d = {29'd0, irq_en_q, timer_en_q, 1'b0};
                6'h01: rdata_d = {scan_cnt_q, 8'd0, 4'(ch_q), 3'd0, busy};
                6'h02: rdata_d = timer_lmt_q;
                6'h03: rdata_d = 32'(mask_q);
                6'h04: rdata_d = 32'(alarm_q);
                default: begin
                    if (ra[5:4] == 2'b01 && int'(ra[3:0]) < CHANNELS)
                        rdata_d = data_q[ra[CH_W-1:0]];
                    else if (ra[5:4] == 2'b10 && int'(ra[3:0]) < CHANNELS)
                        rdata_d = {18'd0, hlim_q[ra[CH_W-1:0]]};
                    else begin
                        rdata_d = 32'hDEC0DEE3;
                        rresp_d = 2'b10;
                    end
                end
            endcase
        end

        // Idle timer; held at zero whenever it is not allowed to count
        timer_d = '0;
        if (!busy && timer_en_q && timer_lmt_q != 32'd0) begin
            if (timer_q == timer_lmt_q - 32'd1) tick = 1'b1;
            else timer_d = timer_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if ((start || tick) && first_ok) begin
                    state_d = S_SEL;
                    ch_d    = first_ch;
                    csn_d   = ~(CHANNELS'(1) << first_ch);
                    cnt_d   = '0;
                end
            end
            S_SEL: begin
                if (cnt_q == HALF_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else cnt_d = cnt_q + 16'd1;
            end
            S_SHIFT: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sh_d   = {sh_q[30:0], MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'd31) begin
                            state_d = S_COMMIT;
                            csn_d   = '1;
                        end else bit_d = bit_q + 5'd1;
                    end
                end else cnt_d = cnt_q + 16'd1;
            end
            S_COMMIT: begin
                csn_d        = '1;
                data_d[ch_q] = sh_q;
                if (sh_q[16] || $signed(sh_q[31:18]) > $signed(hlim_q[ch_q]))
                    alarm_set[ch_q] = 1'b1;
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_M1) begin
                    cnt_d = '0;
                    if (next_ok) begin
                        state_d = S_SEL;
                        ch_d    = next_ch;
                        csn_d   = ~(CHANNELS'(1) << next_ch);
                    end else begin
                        state_d    = S_IDLE;
                        scan_cnt_d = scan_cnt_q + 16'd1;
                    end
                end else cnt_d = cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // A set from COMMIT overrides a simultaneous write-1-to-clear
        alarm_d = (alarm_q & ~w1c) | alarm_set;
        irq_d   = irq_en_q & (|alarm_q);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            sclk_q      <= 1'b0;
            csn_q       <= '1;
            scan_cnt_q  <= '0;
            timer_q     <= '0;
            timer_en_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            timer_lmt_q <= 32'(TIMER_INIT);
            mask_q      <= '1;
            alarm_q     <= '0;
            irq_q       <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                data_q[i] <= '0;
                hlim_q[i] <= 14'h1FFF;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            sclk_q      <= sclk_d;
            csn_q       <= csn_d;
            scan_cnt_q  <= scan_cnt_d;
            timer_q     <= timer_d;
            timer_en_q  <= timer_en_d;
            irq_en_q    <= irq_en_d;
            timer_lmt_q <= timer_lmt_d;
            mask_q      <= mask_d;
            alarm_q     <= alarm_d;
            irq_q       <= irq_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            data_q      <= data_d;
            hlim_q      <= hlim_d;
        end
    end

    assign s_axi_awready = wr_en;
    assign s_axi_wready  = wr_en;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign SCLK          = sclk_q;
    assign CSn           = csn_q;
    assign irq           = irq_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};
endmodule

// File: tb/tb_tc_multi_scan.sv
// Randomized bench for tc_multi_scan: a MAX31855 sensor model on the SPI bus and a
// frame-level scoreboard predicting DATA, ALARM, scan order and scan_count.
module tb_tc_multi_scan;
    localparam int CH = 4;
    localparam int CD = 4;
    localparam int TI = 100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        SCLK, MISO = 1'b0, irq;
    logic [CH-1:0] CSn;

    tc_multi_scan #(.CHANNELS(CH), .CLK_DIV(CD), .TIMER_INIT(TI)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .SCLK(SCLK), .CSn(CSn), .MISO(MISO), .irq(irq));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model and bus monitor
    logic [31:0] frames [CH];
    int          sel_q[$];
    int          rises [CH];
    int          bit_idx = 0, multi_sel = 0;
    logic        prev_sclk = 1'b0;
    logic [CH-1:0] prev_csn = '1;

    function automatic int act_of(input logic [CH-1:0] c);
        int a = 0;
        for (int i = CH - 1; i >= 0; i--) if (c[i] === 1'b0) a = i;
        return a;
    endfunction

    function automatic int lows(input logic [CH-1:0] c);
        int n = 0;
        for (int i = 0; i < CH; i++) if (c[i] === 1'b0) n++;
        return n;
    endfunction

    initial for (int i = 0; i < CH; i++) begin frames[i] = '0; rises[i] = 0; end

    always @(negedge clk) begin : mon
        int ni, a;
        a  = act_of(CSn);
        ni = (&CSn) ? 0 : ((prev_sclk && !SCLK) ? bit_idx + 1 : bit_idx);
        bit_idx <= ni;
        if ((&prev_csn) === 1'b1 && (&CSn) === 1'b0) sel_q.push_back(a);
        if (prev_sclk === 1'b0 && SCLK === 1'b1) rises[a] <= rises[a] + 1;
        if (lows(CSn) > 1) multi_sel <= multi_sel + 1;
        MISO <= ((&CSn) === 1'b0 && ni < 32) ? frames[a][31 - ni] : 1'b0;
        prev_sclk <= SCLK;
        prev_csn  <= CSn;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tout(input string tag);
        n_chk++;
        n_fail++;
        $display("FAIL timeout %s", tag);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] r);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (!bvalid) tout("bvalid");
        r = bresp;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, r);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clk); n++; end
        if (!rvalid) tout("rvalid");
        d = rdata; r = rresp;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk(tag, d, exp);
    endtask

    task automatic wait_cs(input bit low, input int budget, input string tag);
        int n = 0;
        while (((&CSn) == low) && n < budget) begin @(negedge clk); n++; end
        if ((&CSn) == low) tout(tag);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        axi_read(8'h04, d, r);
        while (d[0] && n < 2000) begin axi_read(8'h04, d, r); n++; end
        if (d[0]) tout(tag);
    endtask

    // Scoreboard
    logic [31:0] exp_data [CH];
    logic [31:0] hlim_m [CH];
    logic [CH-1:0] exp_alarm = '0, mask_m = '1;
    int          exp_scan = 0, snap_q = 0;
    int          snap_r [CH];
    logic        irq_en_m = 1'b0;

    function automatic bit alarm_of(input logic [31:0] f, input logic [31:0] h);
        int j, l;
        j = int'((f >> 18) & 32'h3FFF);
        if (j >= 8192) j -= 16384;
        l = int'(h & 32'h3FFF);
        if (l >= 8192) l -= 16384;
        return f[16] || (j > l);
    endfunction

    task automatic begin_scan();
        snap_q = sel_q.size();
        for (int c = 0; c < CH; c++) snap_r[c] = rises[c];
        wr(8'h00, {29'd0, irq_en_m, 1'b0, 1'b1});
    endtask

    task automatic end_scan(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int          ord[$];
        wait_idle(tag);
        for (int c = 0; c < CH; c++) if (mask_m[c]) begin
            ord.push_back(c);
            exp_data[c] = frames[c];
            if (alarm_of(frames[c], hlim_m[c])) exp_alarm[c] = 1'b1;
        end
        if (mask_m != 0) exp_scan++;
        chk({tag, "_nsel"}, sel_q.size() - snap_q, ord.size());
        for (int i = 0; i < ord.size(); i++)
            if (snap_q + i < sel_q.size()) chk({tag, "_order"}, sel_q[snap_q + i], ord[i]);
        for (int c = 0; c < CH; c++)
            chk({tag, "_sclk"}, rises[c] - snap_r[c], mask_m[c] ? 32 : 0);
        for (int c = 0; c < CH; c++) rd_chk({tag, "_data"}, 8'(8'h40 + 4 * c), exp_data[c]);
        rd_chk({tag, "_alarm"}, 8'h10, 32'(exp_alarm));
        axi_read(8'h04, d, r);
        chk({tag, "_scan_cnt"}, {16'd0, d[31:16]}, exp_scan);
    endtask

    task automatic set_mask(input logic [CH-1:0] m);
        wr(8'h0C, 32'(m));
        mask_m = m;
    endtask

    initial begin : main
        logic [31:0] d, s0, s1;
        logic [1:0]  r;
        int          t1, t2, f0;

        for (int c = 0; c < CH; c++) begin exp_data[c] = '0; hlim_m[c] = 32'h1FFF; end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_csn", 32'(CSn), 32'hF);
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_irq", 32'(irq), 0);
        rd_chk("rst_tlmt", 8'h08, TI);
        rd_chk("rst_mask", 8'h0C, 32'hF);
        rd_chk("rst_hlim0", 8'h80, 32'h1FFF);
        rd_chk("rst_cfg", 8'h00, 0);
        rd_chk("rst_status", 8'h04, 0);

        // Directed two-channel scan
        set_mask(4'b0101);
        frames[0] = 32'h01900190;
        frames[1] = $urandom;
        frames[2] = 32'h0640C640;
        frames[3] = $urandom;
        begin_scan();
        end_scan("dir");
        chk("dir_multi_cs", multi_sel, 0);

        // Junction above limit: alarm, irq one cycle after ALARM
        irq_en_m = 1'b1;
        wr(8'h80, 32'h64); hlim_m[0] = 32'h64;
        set_mask(4'b0001);
        frames[0] = 32'h06400000;
        begin_scan();
        wait_cs(1'b1, 100, "alm_cs_low");
        wait_cs(1'b0, 1000, "alm_cs_high");
        @(negedge clk); chk("irq_delay0", 32'(irq), 0);
        @(negedge clk); chk("irq_delay1", 32'(irq), 1);
        end_scan("alm");
        wr(8'h10, 32'h1); exp_alarm[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("irq_clr", 32'(irq), 0);
        frames[0] = 32'h01900000;
        begin_scan();
        end_scan("alm_eq");

        // Fault bit with junction 0, W1C landing in the COMMIT cycle
        frames[0] = 32'h00010000;
        begin_scan();
        wait_cs(1'b1, 100, "flt_cs_low");
        wait_cs(1'b0, 1000, "flt_cs_high");
        awaddr = 8'h10; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        exp_alarm[0] = 1'b0;
        end_scan("flt");
        wr(8'h10, 32'hF); exp_alarm = '0;

        // Randomized scans over channels 0..2
        for (int it = 0; it < 4; it++) begin
            set_mask(3'($urandom_range(1, 7)));
            for (int c = 0; c < CH; c++) begin
                frames[c] = $urandom;
                d = $urandom;
                wr(8'(8'h80 + 4 * c), d);
                hlim_m[c] = d & 32'h3FFF;
            end
            rd_chk("rnd_hlim", 8'h84, hlim_m[1]);
            wr(8'h10, 32'hF); exp_alarm = '0;
            begin_scan();
            end_scan("rnd");
        end

        // DATA read mid-shift with rready held low
        set_mask(4'b0001);
        frames[0] = $urandom;
        begin_scan();
        t1 = 0;
        while (rises[0] - snap_r[0] < 3 && t1 < 500) begin @(negedge clk); t1++; end
        if (rises[0] - snap_r[0] < 3) tout("mid_shift");
        @(negedge clk); araddr = 8'h40; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1 arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(rvalid), 1);
            chk("hold_rdata", rdata, exp_data[0]);
        end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        end_scan("mid");

        // Error responses
        axi_read(8'h14, d, r);
        chk("err_rd_data", d, 32'hDEC0DEE3);
        chk("err_rd_resp", 32'(r), 2);
        axi_read(8'h50, d, r);
        chk("err_rd_ch", 32'(r), 2);
        axi_read(8'h04, s0, r);
        axi_write(8'h04, 32'hFFFFFFFF, r);
        chk("err_wr_resp", 32'(r), 2);
        axi_read(8'h04, s1, r);
        chk("err_wr_status", s1, s0);
        axi_write(8'h40, 32'h12345678, r);
        chk("err_wr_data", 32'(r), 2);
        rd_chk("err_data_kept", 8'h40, exp_data[0]);

        // Timer-driven scans, manual start while busy ignored
        frames[0] = $urandom;
        wr(8'h08, 32'd5000);
        f0 = sel_q.size();
        wr(8'h00, {29'd0, irq_en_m, 1'b1, 1'b0});
        wait_cs(1'b1, 6000, "tmr_first");
        wr(8'h00, {29'd0, irq_en_m, 1'b1, 1'b1});
        wait_cs(1'b0, 1000, "tmr_end1");
        t1 = cyc;
        wait_cs(1'b1, 6000, "tmr_second");
        t2 = cyc;
        chk("tmr_period", t2 - t1, 5001 + 2 * CD);
        wr(8'h00, {29'd0, irq_en_m, 1'b0, 1'b0});
        wait_idle("tmr_idle");
        exp_scan += 2;
        exp_data[0] = frames[0];
        if (alarm_of(frames[0], hlim_m[0])) exp_alarm[0] = 1'b1;
        chk("tmr_nsel", sel_q.size() - f0, 2);
        axi_read(8'h04, d, r);
        chk("tmr_scan_cnt", {16'd0, d[31:16]}, exp_scan);
        rd_chk("tmr_data", 8'h40, exp_data[0]);
        chk("tmr_irq", 32'(irq), 32'(|exp_alarm));

        // TIMER_LMT = 0 never ticks
        wr(8'h08, 32'd0);
        f0 = sel_q.size();
        wr(8'h00, {29'd0, irq_en_m, 1'b1, 1'b0});
        repeat (3000) @(negedge clk);
        chk("tmr0_nsel", sel_q.size() - f0, 0);
        wr(8'h00, 32'd0);

        // Reset in the middle of a shift on a never-committed channel
        set_mask(4'b1000);
        begin_scan();
        t1 = 0;
        while (rises[3] - snap_r[3] < 5 && t1 < 500) begin @(negedge clk); t1++; end
        if (rises[3] - snap_r[3] < 5) tout("rst_mid");
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_csn", 32'(CSn), 32'hF);
        chk("rst_mid_sclk", 32'(SCLK), 0);
        @(negedge clk); rst_n = 1'b1;
        rd_chk("rst_mid_data3", 8'h4C, 0);
        rd_chk("rst_mid_status", 8'h04, 0);
        rd_chk("rst_mid_tlmt", 8'h08, TI);
        rd_chk("rst_mid_hlim0", 8'h80, 32'h1FFF);
        rd_chk("rst_mid_alarm", 8'h10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tc_multi_scan.md
Name: tc_multi_scan

Overview:
- Multi-channel MAX31855 thermocouple scanner. Next generation of the single-sensor Pmod TC1 AXI-Lite interface.
- Drives one shared SCLK/MISO bus with one active-low chip select per channel, and scans enabled channels in ascending index order.
- Stores each channel's raw 32-bit frame, compares the junction temperature against a per-channel high limit, and raises sticky alarms and an interrupt.
- The SPI clock is derived from the AXI clock, so the whole block runs on a single clock domain. Sits on the AXI-Lite peripheral interconnect.

Parameters:
- CHANNELS, 4, number of sensors; 1..16.
- CLK_DIV, 10, SCLK half-period in aclk cycles; >=2. Default gives 5 MHz at 100 MHz.
- TIMER_INIT, 100000, reset value of TIMER_LMT in aclk cycles.
- C_S_AXI_DATA_WIDTH, 32, fixed.
- C_S_AXI_ADDR_WIDTH, 8, byte address width.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  synchronous, active-low reset.
- s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, standard widths; prot and wstrb are ignored.
- SCLK  out  1  SPI clock; idles low.
- CSn  out  CHANNELS  per-channel chip select, active low.
- MISO  in  1  shared serial data.
- irq  out  1  level interrupt.

Behaviour:
- Register map:
  - 0x00 CONFIG: [0] start (write-1, self-clearing, reads 0), [1] timer_en, [2] irq_en.
  - 0x04 STATUS (RO): [0] busy, [7:4] current channel, [31:16] scan_count.
  - 0x08 TIMER_LMT (RW).
  - 0x0C CH_MASK (RW): [CHANNELS-1:0].
  - 0x10 ALARM: [CHANNELS-1:0], write-1-to-clear.
  - 0x40+4*ch DATA (RO): raw frame.
  - 0x80+4*ch HLIM (RW): [13:0] signed limit, same format as the junction field.
- Unmapped addresses, writes to RO registers, and ch >= CHANNELS: write is dropped with bresp SLVERR; read returns 0xDEC0DEE3 with rresp SLVERR.
- Reset values:
  - CONFIG 0, TIMER_LMT TIMER_INIT, CH_MASK all ones, ALARM 0, DATA 0, HLIM 0x1FFF.
  - Outputs: CSn all 1, SCLK 0, irq 0, scan_count 0.
  - AXI valids 0, AXI readies as defined by the handshake rules below.
- AXI write handshake:
  - awready = wready = awvalid & wvalid & ~bvalid; address and data are accepted in the same cycle.
  - bvalid rises the next cycle and holds until bready.
- AXI read handshake:
  - arready = ~rvalid. rdata/rresp are registered at acceptance (1-cycle latency) and held stable until rready.
- Scan start:
  - Triggered by a CONFIG write with bit0=1, or by a timer tick, only when state is IDLE and CH_MASK != 0.
  - Start while busy is ignored; no queuing. Start with an empty mask is ignored.
- Timer:
  - Counts in IDLE when timer_en=1 and TIMER_LMT != 0.
  - Tick fires when count == TIMER_LMT-1; count clears on tick and whenever busy.
- FSM:
  - IDLE -> SEL: pick the lowest enabled channel >= 0.
  - SEL: drive CSn[ch]=0 and wait CLK_DIV cycles (tCSS) -> SHIFT.
  - SHIFT: 32 SCLK periods. SCLK rises after each half-period low. MISO is sampled into a 32-bit shift register on the aclk cycle SCLK goes high, MSB first. SCLK returns low. After the 32nd high phase -> COMMIT.
  - COMMIT (1 cycle): CSn all 1, DATA[ch] <= shift register, alarm check -> GAP.
  - GAP: CLK_DIV*2 cycles with CSn high. Then go to SEL with the next enabled channel above ch; if none, scan_count++ (wraps at 16 bits) -> IDLE.
- CH_MASK is sampled per channel selection. Clearing a channel mid-scan skips it if it has not been reached; the channel in flight completes.
- Alarm:
  - In COMMIT, ALARM[ch] is set if frame bit16 (fault) = 1, or signed frame[31:18] > signed HLIM[ch]. Equal to the limit does not alarm.
  - If a W1C write and a set occur in the same cycle, set wins.
  - irq = irq_en & |ALARM, registered with 1-cycle delay.
- busy = (state != IDLE).
- DATA read during a shift returns the previous committed frame; no torn values.
- Reset asserted mid-transfer: next cycle CSn all 1, SCLK 0, FSM IDLE; partial frame discarded.

Test Plan:
- Reset, then read 0x08, 0x0C, 0x80 -> TIMER_INIT, 0xF, 0x1FFF. CSn=4'hF, SCLK=0, irq=0.
- CH_MASK=0b0101, write CONFIG=1. Model returns 0x01900190 on ch0 and 0x0640C640 on ch2 -> CSn sequence ch0 then ch2, 32 SCLK each. DATA0=0x01900190, DATA2=0x0640C640, scan_count=1. ch1/ch3 CSn never low.
- HLIM0=0x0064 (25.0C), frame junction 0x0190 (100C), irq_en=1 -> after COMMIT ALARM=0x1, irq=1 one cycle later. Write ALARM=0x1 -> irq=0. Junction equal to 0x0064 -> no alarm.
- Frame with bit16=1 and junction 0 -> ALARM[ch] set. W1C write in the same cycle as COMMIT -> bit stays 1.
- timer_en=1, TIMER_LMT=5000 -> scans start every 5000 idle cycles. Manual start while busy -> ignored, scan_count +1 only. TIMER_LMT=0 -> no ticks.
- Read 0x14 -> 0xDEC0DEE3 with SLVERR. Write 0x04 -> SLVERR, STATUS unchanged. rready held low 3 cycles -> rdata stable. Reset mid-SHIFT -> CSn all 1 next cycle, DATA unchanged.
